lif_sequencer: RTL

Byte-stream sequencer that owns the LIF neuron's setup/execute bus. A host pushes framed commands over a valid/ready byte channel. The block turns each frame into neuron register writes or a timed execute burst. After each burst it returns a spike-count result over a second valid/ready channel. It sits between the chip I/O pins and the neuron core, in place of direct pin-driven `data_in`/`setup_control`/`execute`.

---
 rtl/lif_sequencer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/lif_sequencer.sv
// lif_sequencer: turns framed host command bytes into LIF neuron register
// writes or timed execute bursts, and returns a spike count per burst.
// Optional feature macro: LIF_SEQ_TIMESTAMP_EN -- when defined, the result
// frame carries a second byte holding the window index of the first spike.
module lif_sequencer #(
  parameter int RUN_SHIFT     = 3,
  parameter int SPIKE_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] nrn_data,
  output logic [2:0] nrn_ctrl,
  output logic       nrn_execute,
  input  logic       spike_in,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  // Burst length (count+1) << RUN_SHIFT needs 6 + RUN_SHIFT bits.
  localparam int RL_W = 6 + RUN_SHIFT;
  localparam logic [2:0] CTRL_RUN   = 3'b111;
  localparam logic [2:0] CTRL_SHIFT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [7:0]             nrn_data_q, nrn_data_d;
  logic [2:0]             nrn_ctrl_q, nrn_ctrl_d;
  // Bit 0 is the live execute output; bit i is execute delayed by i cycles,
  // so the top bit marks the edges on which spike_in belongs to the burst.
  logic [SPIKE_LATENCY:0] win_q, win_d;
  logic [7:0]             res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic [2:0]             shift_shadow_q, shift_shadow_d;
  logic [2:0]             load_ctrl_q, load_ctrl_d;
  logic [4:0]             left_q, left_d;
  logic [RL_W-1:0]        run_left_q, run_left_d;
  logic [7:0]             cnt_q, cnt_d;
`ifdef LIF_SEQ_TIMESTAMP_EN
  logic [7:0]             sample_idx_q, sample_idx_d;
  logic [7:0]             ts_q, ts_d;
  logic                   res_second_q, res_second_d;
`endif

  logic                   accept;
  logic                   sample;
  logic                   exec_d;
  logic [RL_W-1:0]        run_n;

  assign accept = cmd_valid && cmd_ready_q;
  assign sample = win_q[SPIKE_LATENCY];
  assign run_n  = (RL_W'(cmd_data[4:0]) + RL_W'(1)) << RUN_SHIFT;

  // Next-state, bus parking, spike counting and result handshake.
  always_comb begin
    state_d        = state_q;
    nrn_ctrl_d     = CTRL_SHIFT;
    nrn_data_d     = {5'b0, shift_shadow_q};
    exec_d         = 1'b0;
    res_data_d     = res_data_q;
    res_valid_d    = res_valid_q;
    shift_shadow_d = shift_shadow_q;
    load_ctrl_d    = load_ctrl_q;
    left_d         = left_q;
    run_left_d     = run_left_q;
    cnt_d          = cnt_q;
`ifdef LIF_SEQ_TIMESTAMP_EN
    sample_idx_d   = sample_idx_q;
    ts_d           = ts_q;
    res_second_d   = res_second_q;
`endif

    if (sample && spike_in) begin
      cnt_d = sat_inc(cnt_q, 8'd255);
    end
`ifdef LIF_SEQ_TIMESTAMP_EN
    if (sample) begin
      sample_idx_d = sat_inc(sample_idx_q, 8'd254);
      if (spike_in && (ts_q == 8'hFF)) begin
        ts_d = sample_idx_q;
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_data[7:5] == CTRL_RUN) begin
            state_d    = S_RUN;
            run_left_d = run_n;
            cnt_d      = 8'd0;
`ifdef LIF_SEQ_TIMESTAMP_EN
            sample_idx_d = 8'd0;
            ts_d         = 8'hFF;
`endif
          end else begin
            state_d     = S_LOAD;
            load_ctrl_d = cmd_data[7:5];
            left_d      = cmd_data[4:0];
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          nrn_data_d = cmd_data;
          nrn_ctrl_d = load_ctrl_q;
          if (load_ctrl_q == CTRL_SHIFT) begin
            shift_shadow_d = cmd_data[2:0];
          end
          if (left_q == 5'd0) begin
            state_d = S_IDLE;
          end else begin
            left_d = left_q - 5'd1;
          end
        end
      end
      S_RUN: begin
        exec_d     = 1'b1;
        run_left_d = run_left_q - RL_W'(1);
        if (run_left_q == RL_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The window is empty once the last delayed spike has been sampled.
        if (win_q == '0) begin
          state_d     = S_REPORT;
          res_valid_d = 1'b1;
          res_data_d  = cnt_q;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
`ifdef LIF_SEQ_TIMESTAMP_EN
          if (!res_second_q) begin
            res_data_d   = ts_q;
            res_second_d = 1'b1;
          end else begin
            res_valid_d  = 1'b0;
            res_second_d = 1'b0;
            state_d      = S_IDLE;
          end
`else
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    win_d       = win_q << 1;
    win_d[0]    = exec_d;
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops execute without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b0;
      nrn_data_q     <= 8'h00;
      nrn_ctrl_q     <= CTRL_SHIFT;
      win_q          <= '0;
      res_data_q     <= 8'h00;
      res_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      shift_shadow_q <= 3'd0;
      load_ctrl_q    <= 3'd0;
      left_q         <= 5'd0;
      run_left_q     <= '0;
      cnt_q          <= 8'd0;
`ifdef LIF_SEQ_TIMESTAMP_EN
      sample_idx_q   <= 8'd0;
      ts_q           <= 8'hFF;
      res_second_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      nrn_data_q     <= nrn_data_d;
      nrn_ctrl_q     <= nrn_ctrl_d;
      win_q          <= win_d;
      res_data_q     <= res_data_d;
      res_valid_q    <= res_valid_d;
      busy_q         <= busy_d;
      shift_shadow_q <= shift_shadow_d;
      load_ctrl_q    <= load_ctrl_d;
      left_q         <= left_d;
      run_left_q     <= run_left_d;
      cnt_q          <= cnt_d;
`ifdef LIF_SEQ_TIMESTAMP_EN
      sample_idx_q   <= sample_idx_d;
      ts_q           <= ts_d;
      res_second_q   <= res_second_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign nrn_data    = nrn_data_q;
  assign nrn_ctrl    = nrn_ctrl_q;
  assign nrn_execute = win_q[0];
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;

endmodule
